// File: rtl/r4sdf_stage.sv
`timescale 1ns/1ps
// Radix-4 single-path delay-feedback butterfly stage with run-time inverse,
// optional /4 scaling, input stall, end-of-stream flush and twiddle tags.
module r4sdf_stage #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned FRAME = 2048,
  parameter int unsigned SCALE = 0,
  localparam int unsigned OW = (SCALE != 0) ? WIDTH : WIDTH + 2,
  localparam int unsigned KW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_i,
  input  logic             inverse,
  input  logic             flush,
  output logic             out_valid,
  output logic [OW-1:0]    out_r,
  output logic [OW-1:0]    out_i,
  output logic [1:0]       out_bf,
  output logic [KW-1:0]    out_k,
  output logic             out_sof
);
  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned SW = AW + 1;
  localparam int unsigned CW = KW + 2;
  localparam int unsigned NG = FRAME / (4 * DEPTH);
  localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] grp_q, grp_d;
  logic          pend_q, pend_d;
  logic          inv_q, inv_d;
  logic          rdy_d;
  logic          ov_d, sof_d;
  logic [OW-1:0] or_d, oi_d;
  logic [1:0]    bf_d;
  logic [KW-1:0] k_d;

  // Feedback delay lines; contents are meaningless until pending is set.
  logic [OW-1:0] fb_r [3][DEPTH];
  logic [OW-1:0] fb_i [3][DEPTH];

  logic [1:0]    phase, pidx;
  logic [KW-1:0] slot;
  logic          accept;
  logic          wr_one, wr_all;
  logic [OW-1:0] wr_r, wr_i;
  logic [OW-1:0] rd_r, rd_i;

  logic signed [AW-1:0] ar, ai, br, bi, cr, ci, dr, di;
  logic signed [AW-1:0] y0r, y0i, y2r, y2i, ur, ui, vr, vi;
  logic [OW-1:0] q0r, q0i, q1r, q1i, q2r, q2i, q3r, q3i;

  // Round-half-up /4 when scaling, otherwise pass the full-precision value.
  function automatic logic [OW-1:0] fit(input logic signed [AW-1:0] x);
    logic signed [SW-1:0] t;
    if (SCALE != 0) begin
      t = SW'(x) + SW'(2);
      return OW'(t >>> 2);
    end
    return OW'(x);
  endfunction

  assign phase  = cnt_q[CW-1:KW];
  assign slot   = cnt_q[KW-1:0];
  assign pidx   = (phase == 2'd3) ? 2'd0 : phase;
  assign accept = in_valid & in_ready;
  assign rd_r   = fb_r[pidx][slot];
  assign rd_i   = fb_i[pidx][slot];

  // Radix-4 butterfly; u is a-jb-c+jd, v is a+jb-c-jd, inverse swaps them.
  always_comb begin
    ar  = AW'($signed(fb_r[0][slot]));
    ai  = AW'($signed(fb_i[0][slot]));
    br  = AW'($signed(fb_r[1][slot]));
    bi  = AW'($signed(fb_i[1][slot]));
    cr  = AW'($signed(fb_r[2][slot]));
    ci  = AW'($signed(fb_i[2][slot]));
    dr  = AW'($signed(in_r));
    di  = AW'($signed(in_i));
    y0r = ar + br + cr + dr;
    y0i = ai + bi + ci + di;
    y2r = ar - br + cr - dr;
    y2i = ai - bi + ci - di;
    ur  = ar + bi - cr - di;
    ui  = ai - br - ci + dr;
    vr  = ar - bi - cr + di;
    vi  = ai + br - ci - dr;
    q0r = fit(y0r);
    q0i = fit(y0i);
    q1r = fit(inv_q ? vr : ur);
    q1i = fit(inv_q ? vi : ui);
    q2r = fit(y2r);
    q2i = fit(y2i);
    q3r = fit(inv_q ? ur : vr);
    q3i = fit(inv_q ? ui : vi);
  end

  // Next-state, buffer-write and output selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grp_d   = grp_q;
    pend_d  = pend_q;
    inv_d   = inv_q;
    rdy_d   = in_ready;
    ov_d    = 1'b0;
    sof_d   = out_sof;
    or_d    = out_r;
    oi_d    = out_i;
    bf_d    = out_bf;
    k_d     = out_k;
    wr_one  = 1'b0;
    wr_all  = 1'b0;
    wr_r    = '0;
    wr_i    = '0;

    if (state_q == ST_DRAIN) begin
      ov_d   = 1'b1;
      or_d   = rd_r;
      oi_d   = rd_i;
      bf_d   = phase + 2'd1;
      k_d    = slot;
      sof_d  = 1'b0;
      wr_one = 1'b1;
      if (cnt_q == CW'(3 * DEPTH - 1)) begin
        state_d = ST_RUN;
        rdy_d   = 1'b1;
        pend_d  = 1'b0;
        cnt_d   = '0;
        grp_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (accept) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == '0) inv_d = inverse;
      if (phase != 2'd3) begin
        wr_one = 1'b1;
        wr_r   = OW'($signed(in_r));
        wr_i   = OW'($signed(in_i));
        if (pend_q) begin
          ov_d  = 1'b1;
          or_d  = rd_r;
          oi_d  = rd_i;
          bf_d  = phase + 2'd1;
          k_d   = slot;
          sof_d = 1'b0;
        end
      end else begin
        wr_all = 1'b1;
        ov_d   = 1'b1;
        or_d   = q0r;
        oi_d   = q0i;
        bf_d   = 2'd0;
        k_d    = slot;
        sof_d  = (slot == '0) && (grp_q == '0);
        if (slot == KW'(DEPTH - 1)) begin
          pend_d = 1'b1;
          grp_d  = (grp_q == GW'(NG - 1)) ? '0 : grp_q + GW'(1);
        end
      end
    end else if (flush && !in_valid && (cnt_q == '0) && pend_q) begin
      state_d = ST_DRAIN;
      rdy_d   = 1'b0;
    end
  end

  // Delay-line storage, read-before-write within the same slot.
  always_ff @(posedge clk) begin
    if (wr_all) begin
      fb_r[0][slot] <= q1r;
      fb_i[0][slot] <= q1i;
      fb_r[1][slot] <= q2r;
      fb_i[1][slot] <= q2i;
      fb_r[2][slot] <= q3r;
      fb_i[2][slot] <= q3i;
    end else if (wr_one) begin
      fb_r[pidx][slot] <= wr_r;
      fb_i[pidx][slot] <= wr_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      grp_q     <= '0;
      pend_q    <= 1'b0;
      inv_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_bf    <= '0;
      out_k     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grp_q     <= grp_d;
      pend_q    <= pend_d;
      inv_q     <= inv_d;
      in_ready  <= rdy_d;
      out_valid <= ov_d;
      out_sof   <= sof_d;
      out_r     <= or_d;
      out_i     <= oi_d;
      out_bf    <= bf_d;
      out_k     <= k_d;
    end
  end

endmodule
